// File: rtl/ddr2_arbit.sv
// DDR2 command-bus arbiter: holds the bus for init, then grants refresh > write > read
// one at a time and registers the owner's command/bank/address toward the PHY.
module ddr2_arbit #(
  parameter int unsigned BA_BITS     = 3,
  parameter int unsigned ADDR_BITS   = 13,
  parameter int unsigned MAX_OWN_CYC = 1023
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 init_end,
  input  logic [3:0]           init_cmd,
  input  logic [BA_BITS-1:0]   init_ba,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 aref_req,
  output logic                 aref_en,
  input  logic [3:0]           aref_cmd,
  input  logic [ADDR_BITS-1:0] aref_addr,
  input  logic                 aref_end,
  input  logic                 wr_req,
  output logic                 wr_en,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 wr_end,
  input  logic                 rd_req,
  output logic                 rd_en,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_end,
  output logic                 aref_pending,
  output logic [3:0]           ddr_cmd,
  output logic [BA_BITS-1:0]   ddr_ba,
  output logic [ADDR_BITS-1:0] ddr_addr,
  output logic                 wdog_err
);

  localparam int unsigned      CNT_W    = $clog2(MAX_OWN_CYC + 1);
  localparam logic [3:0]       CMD_NOP  = 4'b0111;
  localparam logic [CNT_W-1:0] OWN_LAST = CNT_W'(MAX_OWN_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       own_q, own_d;
  logic                   aref_en_q, aref_en_d;
  logic                   wr_en_q, wr_en_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wdog_q, wdog_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [BA_BITS-1:0]     ba_q, ba_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   owned_c, end_c;

  // State, grant pulses, watchdog and the single command register stage
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      own_q     <= '0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wdog_q    <= 1'b0;
      cmd_q     <= CMD_NOP;
      ba_q      <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wdog_q    <= wdog_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
    end
  end

  // Next state, grant decode and command mux
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    aref_en_d = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    wdog_d    = wdog_q;
    cmd_d     = CMD_NOP;
    ba_d      = '0;
    addr_d    = '0;
    owned_c   = 1'b0;
    end_c     = 1'b0;

    case (state_q)
      S_INIT: begin
        cmd_d  = init_cmd;
        ba_d   = init_ba;
        addr_d = init_addr;
        if (init_end) state_d = S_ARBIT;
      end
      S_ARBIT: begin
        own_d = '0;
        if (aref_req) begin
          state_d   = S_AREF;
          aref_en_d = 1'b1;
        end else if (wr_req) begin
          state_d = S_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
        end
      end
      S_AREF: begin
        cmd_d   = aref_cmd;
        addr_d  = aref_addr;
        owned_c = 1'b1;
        end_c   = aref_end;
      end
      S_WRITE: begin
        cmd_d   = wr_cmd;
        ba_d    = wr_ba;
        addr_d  = wr_addr;
        owned_c = 1'b1;
        end_c   = wr_end;
      end
      S_READ: begin
        cmd_d   = rd_cmd;
        ba_d    = rd_ba;
        addr_d  = rd_addr;
        owned_c = 1'b1;
        end_c   = rd_end;
      end
      default: state_d = S_INIT;
    endcase

    // Owner release: normal end, or forced when the ownership budget runs out
    if (owned_c) begin
      own_d = own_q + CNT_W'(1);
      if (end_c) begin
        state_d = S_ARBIT;
      end else if (own_q == OWN_LAST) begin
        state_d = S_ARBIT;
        wdog_d  = 1'b1;
      end
    end
  end

  assign aref_pending = ((state_q == S_WRITE) || (state_q == S_READ)) && aref_req;
  assign aref_en      = aref_en_q;
  assign wr_en        = wr_en_q;
  assign rd_en        = rd_en_q;
  assign wdog_err     = wdog_q;
  assign ddr_cmd      = cmd_q;
  assign ddr_ba       = ba_q;
  assign ddr_addr     = addr_q;

endmodule

// File: tb/tb_ddr2_arbit.sv
// Bench for ddr2_arbit: per-cycle vector table with a scoreboard queue of expected
// registered outputs, plus hand-written reset sequences.
module tb_ddr2_arbit;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;

  logic        ck = 1'b0;
  logic        rst;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [2:0]  init_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        aref_en, wr_en, rd_en, aref_pending, wdog_err;
  logic [3:0]  ddr_cmd;
  logic [2:0]  ddr_ba;
  logic [12:0] ddr_addr;

  always #5 ck = ~ck;

  ddr2_arbit #(.BA_BITS(3), .ADDR_BITS(13), .MAX_OWN_CYC(8)) dut (
    .ck(ck), .rst(rst),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_en(aref_en), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .aref_end(aref_end),
    .wr_req(wr_req), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_end(wr_end),
    .rd_req(rd_req), .rd_en(rd_en), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .rd_end(rd_end),
    .aref_pending(aref_pending), .ddr_cmd(ddr_cmd), .ddr_ba(ddr_ba), .ddr_addr(ddr_addr),
    .wdog_err(wdog_err)
  );

  typedef enum int {X_NOP, X_INIT, X_AREF, X_WR, X_RD} sel_t;

  // in = {init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end}
  typedef struct {
    bit [6:0]   in;
    logic [3:0] acmd;
    sel_t       sel;
    bit [2:0]   en;
    bit         pend;
    bit         wd;
  } vec_t;

  typedef struct {
    bit [2:0]    en;
    bit          pend;
    bit          wd;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] addr;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit [6:0] in, logic [3:0] acmd, sel_t sel, bit [2:0] en,
                              bit pend, bit wd);
    vec_t r;
    r.in = in; r.acmd = acmd; r.sel = sel; r.en = en; r.pend = pend; r.wd = wd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".cmd"},  32'(ddr_cmd), 32'(C_NOP));
    chk({tag, ".ba"},   32'(ddr_ba), 32'd0);
    chk({tag, ".addr"}, 32'(ddr_addr), 32'd0);
    chk({tag, ".en"},   32'({aref_en, wr_en, rd_en}), 32'd0);
    chk({tag, ".pend"}, 32'(aref_pending), 32'd0);
    chk({tag, ".wdog"}, 32'(wdog_err), 32'd0);
  endtask

  // Drive one cycle of inputs, queue what must appear after the edge, then compare
  task automatic apply(input vec_t v, input string tag);
    exp_t e, g;
    {init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = v.in;
    aref_cmd = v.acmd;
    e.en = v.en; e.pend = v.pend; e.wd = v.wd;
    case (v.sel)
      X_INIT:  begin e.cmd = C_PRE;  e.ba = 3'd5; e.addr = 13'h0123; end
      X_AREF:  begin e.cmd = v.acmd; e.ba = 3'd0; e.addr = 13'h0400; end
      X_WR:    begin e.cmd = C_WR;   e.ba = 3'd2; e.addr = 13'h0AAA; end
      X_RD:    begin e.cmd = C_RD;   e.ba = 3'd6; e.addr = 13'h1555; end
      default: begin e.cmd = C_NOP;  e.ba = 3'd0; e.addr = 13'h0000; end
    endcase
    sb.push_back(e);
    @(posedge ck);
    #1;
    g = sb.pop_front();
    chk({tag, ".en"},   32'({aref_en, wr_en, rd_en}), 32'(g.en));
    chk({tag, ".pend"}, 32'(aref_pending), 32'(g.pend));
    chk({tag, ".wdog"}, 32'(wdog_err), 32'(g.wd));
    chk({tag, ".cmd"},  32'(ddr_cmd), 32'(g.cmd));
    chk({tag, ".ba"},   32'(ddr_ba), 32'(g.ba));
    chk({tag, ".addr"}, 32'(ddr_addr), 32'(g.addr));
  endtask

  initial begin
    init_cmd = C_PRE; init_ba = 3'd5; init_addr = 13'h0123;
    aref_cmd = C_NOP; aref_addr = 13'h0400;
    wr_cmd = C_WR; wr_ba = 3'd2; wr_addr = 13'h0AAA;
    rd_cmd = C_RD; rd_ba = 3'd6; rd_addr = 13'h1555;
    {init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = 7'd0;
    rst = 1'b1;
    #3;
    chk_reset("rst0");
    @(posedge ck);
    #1;
    rst = 1'b0;

    // Init hold: init command passes through, a write request is not granted
    for (int i = 0; i < 20; i++)
      apply(mk(7'b0010000, C_NOP, X_INIT, 3'b000, 1'b0, 1'b0), $sformatf("init%0d", i));

    tbl.push_back(mk(7'b1000000, C_NOP, X_INIT, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1000000, C_NOP, X_NOP,  3'b000, 0, 0));
    // Simultaneous requests: refresh wins, then write, then read
    tbl.push_back(mk(7'b1111000, C_NOP, X_NOP,  3'b100, 0, 0));
    tbl.push_back(mk(7'b1011000, C_PRE, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1011000, C_NOP, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1011000, C_NOP, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1011000, C_NOP, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1011000, C_NOP, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1011000, C_REF, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1011100, C_NOP, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1011000, C_NOP, X_NOP,  3'b010, 0, 0));
    tbl.push_back(mk(7'b1001001, C_NOP, X_WR,   3'b000, 0, 0));
    // Refresh request during write raises pending; write end hands over to refresh
    tbl.push_back(mk(7'b1101000, C_NOP, X_WR,   3'b000, 1, 0));
    tbl.push_back(mk(7'b1101010, C_NOP, X_WR,   3'b000, 0, 0));
    tbl.push_back(mk(7'b1101000, C_NOP, X_NOP,  3'b100, 0, 0));
    tbl.push_back(mk(7'b1001100, C_NOP, X_AREF, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1001000, C_NOP, X_NOP,  3'b001, 0, 0));
    // Read owner never ends: forced release after 8 owned cycles
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(7'b1000000, C_NOP, X_RD, 3'b000, 0, 0));
    tbl.push_back(mk(7'b1000000, C_NOP, X_RD,   3'b000, 0, 1));
    tbl.push_back(mk(7'b1001000, C_NOP, X_NOP,  3'b001, 0, 1));
    tbl.push_back(mk(7'b1000001, C_NOP, X_RD,   3'b000, 0, 1));
    tbl.push_back(mk(7'b1010000, C_NOP, X_NOP,  3'b010, 0, 1));
    tbl.push_back(mk(7'b1100000, C_NOP, X_WR,   3'b000, 1, 1));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("r%0d", i));

    // Asynchronous reset while a write owns the bus
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    {init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end} = 7'b0010000;
    @(posedge ck);
    #1;
    chk_reset("rst_hold");
    rst = 1'b0;
    apply(mk(7'b0010000, C_NOP, X_INIT, 3'b000, 0, 0), "post0");
    apply(mk(7'b0010000, C_NOP, X_INIT, 3'b000, 0, 0), "post1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
